// File: rtl/mpt_fetch_stage.sv
// Walker fetch stage: reads the MPT entry addressed by mpte and replaces mpte with it; skip/invalid bypass memory.
// Latency: bypass 1 cycle; walk 1 cycle to request, then output the cycle after the response.
// Backpressure: single transaction in flight; output held until stage_master_ready, upstream ready only while draining.
module mpt_fetch_stage #(
    parameter int PIPELINE_SLAVE_DATA_WIDTH  = 253,
    parameter int PIPELINE_MASTER_DATA_WIDTH = 253,
    parameter int WALKING_LEVEL              = 0,
    parameter int MEM_ADDR_WIDTH             = 64,
    parameter int MEM_DATA_WIDTH             = 64
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  stage_slave_valid,
    output logic                                  stage_slave_ready,
    input  logic [PIPELINE_SLAVE_DATA_WIDTH-1:0]  stage_slave_data,
    output logic                                  stage_master_valid,
    input  logic                                  stage_master_ready,
    output logic [PIPELINE_MASTER_DATA_WIDTH-1:0] stage_master_data,
    output logic                                  mem_req_o,
    input  logic                                  mem_gnt_i,
    output logic [MEM_ADDR_WIDTH-1:0]             mem_addr_o,
    input  logic                                  mem_rvalid_i,
    input  logic [MEM_DATA_WIDTH-1:0]             mem_rdata_i,
    input  logic                                  mem_err_i,
    output logic                                  bus_error_o
);

    localparam logic [1:0] MPT_WALKING_ACTIVE = 2'd0;
    localparam logic [1:0] MPT_WALKING_SKIP   = 2'd1;

    // Packed layout of mptw_transaction_t, MSB first; shared with the parsing stage.
    typedef struct packed {
        logic [7:0]  id;
        logic [43:0] mmpt;
        logic [63:0] spa;
        logic [1:0]  access_type;
        logic [63:0] rpa;
        logic        plb_hit;
        logic        format_error;
        logic        access_error;
        logic        completed;
        logic [1:0]  walking;
        logic        valid;
        logic [63:0] mpte;
    } mptw_transaction_t;

    localparam int TXN_W = $bits(mptw_transaction_t);

    if (PIPELINE_MASTER_DATA_WIDTH != PIPELINE_SLAVE_DATA_WIDTH) begin : g_bad_width
        $error("stage_master_data width must equal stage_slave_data width");
    end
    if (PIPELINE_SLAVE_DATA_WIDTH != TXN_W) begin : g_bad_txn_width
        $error("stage data width does not match the packed transaction width");
    end
    if (MEM_DATA_WIDTH > 64 || MEM_ADDR_WIDTH > 64 || MEM_ADDR_WIDTH < 4) begin : g_bad_mem
        $error("memory widths must fit the 64-bit mpte field");
    end
    if (WALKING_LEVEL < 0) begin : g_bad_level
        $error("WALKING_LEVEL must be non-negative");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t            state, state_n;
    mptw_transaction_t data_q;
    mptw_transaction_t in_txn;
    mptw_transaction_t resp_txn;
    logic              bus_error_q;
    logic              slave_rdy_c;
    logic              accept;
    logic              take_resp;

    assign in_txn = mptw_transaction_t'(stage_slave_data);

    function automatic state_t route(input mptw_transaction_t t);
        return (!t.valid || t.walking == MPT_WALKING_SKIP) ? OUT : REQ;
    endfunction

    always_comb begin
        state_n     = state;
        slave_rdy_c = 1'b0;
        accept      = 1'b0;
        take_resp   = 1'b0;
        case (state)
            IDLE: begin
                slave_rdy_c = 1'b1;
                if (stage_slave_valid) begin
                    accept  = 1'b1;
                    state_n = route(in_txn);
                end
            end
            REQ: begin
                if (mem_gnt_i) begin
                    if (mem_rvalid_i) begin
                        take_resp = 1'b1;
                        state_n   = OUT;
                    end else begin
                        state_n = WAIT;
                    end
                end
            end
            WAIT: begin
                if (mem_rvalid_i) begin
                    take_resp = 1'b1;
                    state_n   = OUT;
                end
            end
            OUT: begin
                slave_rdy_c = stage_master_ready;
                if (stage_master_ready) begin
                    if (stage_slave_valid) begin
                        accept  = 1'b1;
                        state_n = route(in_txn);
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // An errored fetch terminates the walk: the parser sees a completed, skipped transaction.
    always_comb begin
        resp_txn      = data_q;
        resp_txn.mpte = '0;
        if (mem_err_i) begin
            resp_txn.completed    = 1'b1;
            resp_txn.walking      = MPT_WALKING_SKIP;
            resp_txn.access_error = 1'b1;
        end else begin
            resp_txn.mpte[MEM_DATA_WIDTH-1:0] = mem_rdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q      <= '0;
            bus_error_q <= 1'b0;
        end else begin
            bus_error_q <= take_resp & mem_err_i;
            if (accept) begin
                data_q <= in_txn;
            end else if (take_resp) begin
                data_q <= resp_txn;
            end
        end
    end

    assign stage_slave_ready  = slave_rdy_c & ~rst_i;
    assign stage_master_valid = (state == OUT);
    assign stage_master_data  = data_q;
    assign mem_req_o          = (state == REQ);
    assign mem_addr_o         = (state == REQ) ? {data_q.mpte[MEM_ADDR_WIDTH-1:3], 3'b000} : '0;
    assign bus_error_o        = bus_error_q;

    // Keep the walking-active encoding visible to readers; only SKIP steers routing here.
    logic unused_walk_enc;
    assign unused_walk_enc = ^MPT_WALKING_ACTIVE;

endmodule

// File: tb/tb_mpt_fetch_stage.sv
module tb_mpt_fetch_stage;

    localparam int W = 253;
    localparam logic [1:0] WALK_ACTIVE = 2'd0;
    localparam logic [1:0] WALK_SKIP   = 2'd1;

    typedef struct packed {
        logic [7:0]  id;
        logic [43:0] mmpt;
        logic [63:0] spa;
        logic [1:0]  access_type;
        logic [63:0] rpa;
        logic        plb_hit;
        logic        format_error;
        logic        access_error;
        logic        completed;
        logic [1:0]  walking;
        logic        valid;
        logic [63:0] mpte;
    } txn_t;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          stage_slave_valid = 1'b0;
    logic          stage_slave_ready;
    logic [W-1:0]  stage_slave_data = '0;
    logic          stage_master_valid;
    logic          stage_master_ready = 1'b1;
    logic [W-1:0]  stage_master_data;
    logic          mem_req_o;
    logic          mem_gnt_i = 1'b0;
    logic [63:0]   mem_addr_o;
    logic          mem_rvalid_i = 1'b0;
    logic [63:0]   mem_rdata_i = '0;
    logic          mem_err_i = 1'b0;
    logic          bus_error_o;

    always #5 clk = ~clk;

    mpt_fetch_stage #(
        .PIPELINE_SLAVE_DATA_WIDTH (W),
        .PIPELINE_MASTER_DATA_WIDTH(W),
        .WALKING_LEVEL             (0),
        .MEM_ADDR_WIDTH            (64),
        .MEM_DATA_WIDTH            (64)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst_i),
        .stage_slave_valid (stage_slave_valid),
        .stage_slave_ready (stage_slave_ready),
        .stage_slave_data  (stage_slave_data),
        .stage_master_valid(stage_master_valid),
        .stage_master_ready(stage_master_ready),
        .stage_master_data (stage_master_data),
        .mem_req_o         (mem_req_o),
        .mem_gnt_i         (mem_gnt_i),
        .mem_addr_o        (mem_addr_o),
        .mem_rvalid_i      (mem_rvalid_i),
        .mem_rdata_i       (mem_rdata_i),
        .mem_err_i         (mem_err_i),
        .bus_error_o       (bus_error_o)
    );

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   req_cycles = 0;
    int   berr_cycles = 0;
    txn_t exp_q[$];
    int   out_cycs[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every accepted output is checked against the oldest expectation.
    always @(negedge clk) begin
        if (mem_req_o) req_cycles++;
        if (bus_error_o) berr_cycles++;
        if (!rst_i && stage_master_valid && stage_master_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_output: got %h expected no output", stage_master_data);
            end else begin
                txn_t e;
                e = exp_q.pop_front();
                chk("out_txn", 256'(stage_master_data), 256'(e));
                out_cycs.push_back(cyc);
            end
        end
    end

    task automatic send(input txn_t t, input bit push, input txn_t e, output int acc_cyc);
        bit rdy;
        int n;
        stage_slave_valid = 1'b1;
        stage_slave_data  = t;
        n       = 0;
        acc_cyc = -1;
        do begin
            @(negedge clk);
            rdy     = stage_slave_ready;
            acc_cyc = cyc;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 100);
        if (!rdy) chk("send_timeout", 256'(rdy), 256'(1));
        else if (push) exp_q.push_back(e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || stage_master_valid) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) chk("drain_timeout", 256'(exp_q.size()), 256'(0));
        @(posedge clk);
        #1;
    endtask

    function automatic txn_t mk(input logic [7:0] id, input logic [1:0] walking,
                                input logic valid, input logic [63:0] mpte);
        txn_t t;
        t              = '0;
        t.id           = id;
        t.mmpt         = 44'h0AB_CDEF_0123;
        t.spa          = 64'h0000_1234_5678_9000 + 64'(id);
        t.access_type  = 2'd2;
        t.rpa          = 64'hFEED_0000_0000_0000 | 64'(id);
        t.plb_hit      = id[0];
        t.format_error = id[1];
        t.walking      = walking;
        t.valid        = valid;
        t.mpte         = mpte;
        return t;
    endfunction

    initial begin
        txn_t t, e;
        int   acc, r0, b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_slave_ready", 256'(stage_slave_ready), 256'(0));
        chk("rst_master_valid", 256'(stage_master_valid), 256'(0));
        chk("rst_master_data", 256'(stage_master_data), 256'(0));
        chk("rst_mem_req", 256'(mem_req_o), 256'(0));
        chk("rst_mem_addr", 256'(mem_addr_o), 256'(0));
        chk("rst_bus_error", 256'(bus_error_o), 256'(0));
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(negedge clk);
        chk("idle_slave_ready", 256'(stage_slave_ready), 256'(1));
        @(posedge clk); #1;

        // Skip: bypass unchanged, output one cycle after the handshake.
        t = mk(8'h01, WALK_SKIP, 1'b1, 64'h1234);
        out_cycs.delete();
        r0 = req_cycles;
        send(t, 1'b1, t, acc);
        stage_slave_valid = 1'b0;
        drain();
        chk("skip_latency", 256'(out_cycs.size() > 0 ? out_cycs[0] : -1), 256'(acc + 1));
        chk("skip_no_mem_req", 256'(req_cycles - r0), 256'(0));

        // valid==0 bypasses memory even when walking is active.
        t = mk(8'h02, WALK_ACTIVE, 1'b0, 64'h8000_0000);
        r0 = req_cycles;
        send(t, 1'b1, t, acc);
        stage_slave_valid = 1'b0;
        drain();
        chk("invalid_no_mem_req", 256'(req_cycles - r0), 256'(0));

        // Walk with delayed grant and delayed response.
        t = mk(8'h03, WALK_ACTIVE, 1'b1, 64'h8000_0013);
        e = t;
        e.mpte = 64'h0000_0000_0040_0001;
        send(t, 1'b1, e, acc);
        stage_slave_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("walk_req_held", 256'(mem_req_o), 256'(1));
            chk("walk_addr", 256'(mem_addr_o), 256'(64'h8000_0010));
            @(posedge clk); #1;
        end
        mem_gnt_i = 1'b1;
        @(negedge clk);
        chk("walk_addr_at_gnt", 256'(mem_addr_o), 256'(64'h8000_0010));
        @(posedge clk); #1;
        mem_gnt_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("walk_wait_no_req", 256'(mem_req_o), 256'(0));
            chk("walk_wait_no_valid", 256'(stage_master_valid), 256'(0));
            @(posedge clk); #1;
        end
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 64'h0000_0000_0040_0001;
        @(posedge clk); #1;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        drain();

        // Backpressure with a zero-wait grant+response.
        stage_master_ready = 1'b0;
        t = mk(8'h04, WALK_ACTIVE, 1'b1, 64'h0000_0000_9000_000C);
        e = t;
        e.mpte = 64'h0123_4567_89AB_CDEF;
        send(t, 1'b1, e, acc);
        stage_slave_valid = 1'b0;
        mem_gnt_i    = 1'b1;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 64'h0123_4567_89AB_CDEF;
        @(posedge clk); #1;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        r0 = req_cycles;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 256'(stage_master_valid), 256'(1));
            chk("bp_data_stable", 256'(stage_master_data), 256'(e));
            chk("bp_slave_ready", 256'(stage_slave_ready), 256'(0));
            @(posedge clk); #1;
        end
        chk("bp_no_second_req", 256'(req_cycles - r0), 256'(0));
        stage_master_ready = 1'b1;
        drain();
        @(negedge clk);
        chk("bp_back_idle_ready", 256'(stage_slave_ready), 256'(1));
        chk("bp_back_idle_valid", 256'(stage_master_valid), 256'(0));
        @(posedge clk); #1;

        // Bus error in WAIT.
        b0 = berr_cycles;
        t = mk(8'h05, WALK_ACTIVE, 1'b1, 64'h0000_0000_0000_1000);
        e = t;
        e.mpte         = '0;
        e.completed    = 1'b1;
        e.walking      = WALK_SKIP;
        e.access_error = 1'b1;
        send(t, 1'b1, e, acc);
        stage_slave_valid = 1'b0;
        mem_gnt_i = 1'b1;
        @(posedge clk); #1;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_err_i    = 1'b1;
        mem_rdata_i  = 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge clk); #1;
        mem_rvalid_i = 1'b0;
        mem_err_i    = 1'b0;
        mem_rdata_i  = '0;
        drain();
        chk("bus_error_pulse", 256'(berr_cycles - b0), 256'(1));

        // Reset in WAIT; late response must be ignored.
        t = mk(8'h06, WALK_ACTIVE, 1'b1, 64'h0000_0000_0000_2000);
        send(t, 1'b0, t, acc);
        stage_slave_valid = 1'b0;
        mem_gnt_i = 1'b1;
        @(posedge clk); #1;
        mem_gnt_i = 1'b0;
        rst_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_wait_slave_ready", 256'(stage_slave_ready), 256'(0));
        chk("rst_wait_master_valid", 256'(stage_master_valid), 256'(0));
        chk("rst_wait_data", 256'(stage_master_data), 256'(0));
        chk("rst_wait_mem_req", 256'(mem_req_o), 256'(0));
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(posedge clk); #1;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 64'hDEAD_BEEF_DEAD_BEEF;
        @(posedge clk); #1;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("late_rvalid_no_out", 256'(stage_master_valid), 256'(0));
            chk("late_rvalid_data", 256'(stage_master_data), 256'(0));
            @(posedge clk); #1;
        end
        t = mk(8'h07, WALK_ACTIVE, 1'b1, 64'h0000_0000_0000_300F);
        e = t;
        e.mpte = 64'h0000_0000_0000_0055;
        send(t, 1'b1, e, acc);
        stage_slave_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_addr", 256'(mem_addr_o), 256'(64'h3008));
        @(posedge clk); #1;
        mem_gnt_i    = 1'b1;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 64'h55;
        @(posedge clk); #1;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        drain();

        // Back-to-back skips at full throughput.
        out_cycs.delete();
        for (int i = 0; i < 4; i++) begin
            t = mk(8'h10 + 8'(i), WALK_SKIP, 1'b1, 64'h100 * 64'(i + 1));
            send(t, 1'b1, t, acc);
        end
        stage_slave_valid = 1'b0;
        drain();
        chk("b2b_count", 256'(out_cycs.size()), 256'(4));
        if (out_cycs.size() == 4) begin
            for (int i = 1; i < 4; i++) begin
                chk("b2b_consecutive", 256'(out_cycs[i] - out_cycs[i-1]), 256'(1));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
